// File: rtl/riscv_uc_pkg.sv
// Shared definitions for the pipelined RV64 control unit.
// It holds the opcode constants, the ALUControl, ImmSrc and ResultSrc codes,
// and the per-stage control bundles that travel D->E->M->W.
package riscv_uc_pkg;

    localparam int unsigned AluCtrlW = 4;

    localparam logic [6:0] OpBubble = 7'b0000000;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpAluI   = 7'b0010011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpAluR   = 7'b0110011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [AluCtrlW-1:0] AluAdd  = 4'b0000;
    localparam logic [AluCtrlW-1:0] AluSub  = 4'b0001;
    localparam logic [AluCtrlW-1:0] AluAnd  = 4'b0010;
    localparam logic [AluCtrlW-1:0] AluOr   = 4'b0011;
    localparam logic [AluCtrlW-1:0] AluXor  = 4'b0100;
    localparam logic [AluCtrlW-1:0] AluSlt  = 4'b0101;
    localparam logic [AluCtrlW-1:0] AluSll  = 4'b0110;
    localparam logic [AluCtrlW-1:0] AluSrl  = 4'b0111;
    localparam logic [AluCtrlW-1:0] AluSra  = 4'b1000;
    localparam logic [AluCtrlW-1:0] AluSltu = 4'b1001;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    localparam logic [1:0] ResAlu = 2'b00;
    localparam logic [1:0] ResMem = 2'b01;
    localparam logic [1:0] ResPc4 = 2'b10;

    // bne selects the inverted zero test when branch is set
    typedef struct packed {
        logic                reg_write;
        logic [1:0]          result_src;
        logic                mem_write;
        logic                jump;
        logic                branch;
        logic                bne;
        logic [AluCtrlW-1:0] alu_control;
        logic                alu_src;
        logic                illegal;
    } ctrl_e_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } ctrl_m_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } ctrl_w_t;

    // ALU operation from func3; alt is func7[5] and only chooses sub/sra
    function automatic logic [AluCtrlW-1:0] alu_op(logic [2:0] f3, logic alt);
        logic [AluCtrlW-1:0] op;
        case (f3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pipelined_riscv_uc_if.sv
// Control-unit bus: Decode-stage instruction fields and hazard inputs in,
// per-stage control bits out. master = datapath/hazard side, slave = control unit.
interface pipelined_riscv_uc_if #(
    parameter int unsigned ALU_CTRL_W = 4
);
    logic [6:0]            opcode;
    logic [2:0]            func3;
    logic [6:0]            func7;
    logic                  zeroE;
    logic                  FlushE;
    logic [1:0]            ImmSrcD;
    logic                  ALUSrcE;
    logic [ALU_CTRL_W-1:0] ALUControlE;
    logic                  PCSrcE;
    logic [1:0]            ResultSrcE;
    logic                  MemWriteM;
    logic                  RegWriteM;
    logic                  RegWriteW;
    logic [1:0]            ResultSrcW;
    logic                  illegal_instr;

    modport master (
        output opcode, func3, func7, zeroE, FlushE,
        input  ImmSrcD, ALUSrcE, ALUControlE, PCSrcE, ResultSrcE,
               MemWriteM, RegWriteM, RegWriteW, ResultSrcW, illegal_instr
    );

    modport slave (
        input  opcode, func3, func7, zeroE, FlushE,
        output ImmSrcD, ALUSrcE, ALUControlE, PCSrcE, ResultSrcE,
               MemWriteM, RegWriteM, RegWriteW, ResultSrcW, illegal_instr
    );
endinterface

// File: rtl/uc_decoder.sv
// Combinational instruction decoder for the Decode stage.
// Ports: opcode/func3/func7 in; ctrl (E-stage bundle incl. illegal) and imm_src out.
// Illegal or bubble opcodes produce an all-zero bundle; only illegal sets ctrl.illegal.
module uc_decoder
    import riscv_uc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output ctrl_e_t    ctrl,
    output logic [1:0] imm_src
);
    logic unused_func7;
    assign unused_func7 = ^{func7[6], func7[4:0]};

    always_comb begin
        ctrl    = '0;
        imm_src = ImmI;
        case (opcode)
            OpAluR: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_control = alu_op(func3, func7[5]);
            end
            OpAluI: begin
                ctrl.reg_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                // func7[5] is immediate data for addi, so it only matters for shifts
                ctrl.alu_control = alu_op(func3, func7[5] && (func3 == 3'b101));
            end
            OpLoad: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = ResMem;
            end
            OpStore: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = ImmS;
            end
            OpBranch: begin
                if (func3[2:1] == 2'b00) begin
                    ctrl.branch      = 1'b1;
                    ctrl.bne         = func3[0];
                    ctrl.alu_control = AluSub;
                    imm_src          = ImmB;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            OpJal: begin
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = ResPc4;
                imm_src         = ImmJ;
            end
            OpBubble: ;
            default: ctrl.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/pipelined_riscv_uc.sv
// Pipelined control unit for the 5-stage RV64 core.
// Ports: clock, reset (sync, active-high); bus (slave) carries D-stage fields,
// zeroE/FlushE in, and per-stage control plus the sticky illegal_instr flag out.
module pipelined_riscv_uc
    import riscv_uc_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W = 4
) (
    input logic                  clock,
    input logic                  reset,
    pipelined_riscv_uc_if.slave  bus
);
    ctrl_e_t ctrl_d;
    ctrl_e_t ctrl_e_q;
    ctrl_m_t ctrl_m_q;
    ctrl_w_t ctrl_w_q;
    logic    illegal_q;
    logic    cond_e;

    uc_decoder u_decoder (
        .opcode  (bus.opcode),
        .func3   (bus.func3),
        .func7   (bus.func7),
        .ctrl    (ctrl_d),
        .imm_src (bus.ImmSrcD)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_e_q  <= '0;
            ctrl_m_q  <= '0;
            ctrl_w_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            // A flushed illegal instruction never reaches E, so it never sets the flag
            ctrl_e_q  <= bus.FlushE ? '0 : ctrl_d;
            ctrl_m_q  <= '{reg_write:  ctrl_e_q.reg_write,
                           result_src: ctrl_e_q.result_src,
                           mem_write:  ctrl_e_q.mem_write};
            ctrl_w_q  <= '{reg_write:  ctrl_m_q.reg_write,
                           result_src: ctrl_m_q.result_src};
            illegal_q <= illegal_q | ctrl_e_q.illegal;
        end
    end

    assign cond_e = ctrl_e_q.bne ? ~bus.zeroE : bus.zeroE;

    assign bus.PCSrcE        = ctrl_e_q.jump | (ctrl_e_q.branch & cond_e);
    assign bus.ALUSrcE       = ctrl_e_q.alu_src;
    assign bus.ALUControlE   = ALU_CTRL_W'(ctrl_e_q.alu_control);
    assign bus.ResultSrcE    = ctrl_e_q.result_src;
    assign bus.MemWriteM     = ctrl_m_q.mem_write;
    assign bus.RegWriteM     = ctrl_m_q.reg_write;
    assign bus.RegWriteW     = ctrl_w_q.reg_write;
    assign bus.ResultSrcW    = ctrl_w_q.result_src;
    assign bus.illegal_instr = illegal_q;
endmodule
